// File: rtl/frame_cfg_pkg.sv
// ============================================================================
// Module  : frame_cfg_pkg
// Brief   : Shared opcodes, word width and FSM state type for the frame sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package frame_cfg_pkg;

    localparam int          CFG_WORD_W = 32;
    localparam logic [3:0]  OP_WRITE   = 4'h1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/frame_strobe_decoder.sv
// ============================================================================
// Module  : frame_strobe_decoder
// Brief   : Frame index to one-hot strobe select, with range check.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module frame_strobe_decoder #(
    parameter int MaxFramesPerCol = 20
) (
    input  logic [7:0]                 i_index,
    output logic [MaxFramesPerCol-1:0] o_oneHot,
    output logic                       o_inRange
);

    always_comb begin
        o_oneHot  = '0;
        o_inRange = (int'(i_index) < MaxFramesPerCol);
        // Indices beyond the column width match no bit, so out-of-range yields all-zero.
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            o_oneHot[i] = (i_index == 8'(i));
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_config_sequencer.sv
// ============================================================================
// Module  : frame_config_sequencer
// Brief   : Assembles a column frame from a word stream and strobes it into latches.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module frame_config_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 9,
    parameter int StrobeCycles    = 2
) (
    input  logic                               CLK,
    input  logic                               resetn,
    input  logic [CFG_WORD_W-1:0]              s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic [FrameBitsPerRow*NumRows-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               err_addr,
    input  logic                               err_clr
);

    localparam int c_ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int c_STR_W = $clog2(StrobeCycles + 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(NumRows - 1);
    localparam logic [c_STR_W-1:0] c_STR_LAST = c_STR_W'(StrobeCycles - 1);

    state_t                       r_state;
    logic [c_ROW_W-1:0]           r_rowCnt;
    logic [c_STR_W-1:0]           r_strbCnt;
    logic [MaxFramesPerCol-1:0]   r_strobeSel;
    logic                         r_badIdx;

    logic [MaxFramesPerCol-1:0]   w_oneHot;
    logic                         w_inRange;
    logic                         w_xfer;
    logic                         w_writeCmd;
    logic                         w_cmdErr;

    frame_strobe_decoder #(
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_decoder (
        .i_index   (s_data[7:0]),
        .o_oneHot  (w_oneHot),
        .o_inRange (w_inRange)
    );

    assign w_xfer     = s_valid && s_ready;
    assign w_writeCmd = (r_state == ST_IDLE) && w_xfer && (s_data[31:28] == OP_WRITE);
    assign w_cmdErr   = w_writeCmd && !w_inRange;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_rowCnt    <= '0;
            r_strbCnt   <= '0;
            r_strobeSel <= '0;
            r_badIdx    <= 1'b0;
            s_ready     <= 1'b0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_addr    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // A new range error takes priority over a simultaneous clear.
            if (w_cmdErr) begin
                err_addr <= 1'b1;
            end else if (err_clr) begin
                err_addr <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                    if (w_writeCmd) begin
                        r_state     <= ST_LOAD;
                        r_rowCnt    <= '0;
                        r_badIdx    <= !w_inRange;
                        r_strobeSel <= w_oneHot;
                        busy        <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (w_xfer) begin
                        for (int r = 0; r < NumRows; r++) begin
                            if (!r_badIdx && (r_rowCnt == c_ROW_W'(r))) begin
                                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                            end
                        end
                        if (r_rowCnt == c_ROW_LAST) begin
                            r_rowCnt <= '0;
                            if (r_badIdx) begin
                                r_state <= ST_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                r_state <= ST_SETUP;
                                s_ready <= 1'b0;
                            end
                        end else begin
                            r_rowCnt <= r_rowCnt + 1'b1;
                        end
                    end
                end

                ST_SETUP: begin
                    r_state     <= ST_STROBE;
                    r_strbCnt   <= '0;
                    FrameStrobe <= r_strobeSel;
                end

                ST_STROBE: begin
                    if (r_strbCnt == c_STR_LAST) begin
                        r_state     <= ST_HOLD;
                        FrameStrobe <= '0;
                        frame_done  <= 1'b1;
                    end else begin
                        r_strbCnt <= r_strbCnt + 1'b1;
                    end
                end

                ST_HOLD: begin
                    r_state <= ST_IDLE;
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    FrameStrobe <= '0;
                    s_ready     <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
